// File: rtl/hmmm_pkg.sv
// Shared constants and state encoding for the Hmmm ALU sequencer.
// Imported by the sequencer and its bench.
package hmmm_pkg;

  localparam int WIDTH = 16;
  localparam int RA_W  = 4;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_MOD  = 3'd4;
  localparam logic [2:0] NUM_OPS = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_Y,
    S_RD_Z,
    S_LATCH,
    S_EXEC,
    S_WB
  } state_e;

endpackage

// File: rtl/hmmm_alu_sequencer.sv
// Operand fetch / ALU drive / writeback sequencer for the Hmmm ALU.
// One request every six cycles through a single sync read port.
module hmmm_alu_sequencer
  import hmmm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [RA_W-1:0]  req_rx,
  input  logic [RA_W-1:0]  req_ry,
  input  logic [RA_W-1:0]  req_rz,
  output logic [RA_W-1:0]  rf_raddr,
  input  logic [WIDTH-1:0] rf_rdata,
  output logic             rf_we,
  output logic [RA_W-1:0]  rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  output logic [WIDTH-1:0] tmp1,
  output logic [WIDTH-1:0] tmp2,
  output logic [2:0]       alu_op,
  output logic             alu_enable,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             done,
  output logic             err
);

  state_e state_q, state_d;

  logic [2:0]       op_q;
  logic [2:0]       aluop_q;
  logic [RA_W-1:0]  rx_q;
  logic [RA_W-1:0]  ry_q;
  logic [RA_W-1:0]  rz_q;
  logic [RA_W-1:0]  raddr_q;
  logic [WIDTH-1:0] tmp1_q;
  logic [WIDTH-1:0] tmp2_q;
  logic [WIDTH-1:0] res_q;
  logic             rzero_q;
  logic             rcarry_q;
  logic             err_q;
  logic             ill_q;
  logic             fz_q;
  logic             fc_q;

  logic bad_op;
  logic div0;
  logic fault;

  assign bad_op = (aluop_q >= NUM_OPS);
  assign div0   = ((aluop_q == OP_DIV) ||
                   (aluop_q == OP_MOD)) &&
                  (tmp2_q == '0);
  assign fault  = bad_op | div0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req_valid) state_d = S_RD_Y;
      S_RD_Y:  state_d = S_RD_Z;
      S_RD_Z:  state_d = S_LATCH;
      S_LATCH: state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    alu_enable = 1'b0;
    rf_we      = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    unique case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_EXEC: alu_enable = !fault;
      S_WB: begin
        rf_we = !ill_q && (rx_q != '0);
        done  = 1'b1;
        err   = err_q;
      end
      default: ;
    endcase
  end

  // Read data lags the address by one cycle, so each operand
  // is latched one state after its address was presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      aluop_q  <= '0;
      rx_q     <= '0;
      ry_q     <= '0;
      rz_q     <= '0;
      raddr_q  <= '0;
      tmp1_q   <= '0;
      tmp2_q   <= '0;
      res_q    <= '0;
      rzero_q  <= 1'b0;
      rcarry_q <= 1'b0;
      err_q    <= 1'b0;
      ill_q    <= 1'b0;
      fz_q     <= 1'b0;
      fc_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (req_valid) begin
          op_q    <= req_op;
          rx_q    <= req_rx;
          ry_q    <= req_ry;
          rz_q    <= req_rz;
          raddr_q <= req_ry;
        end
        S_RD_Y: raddr_q <= rz_q;
        S_RD_Z: tmp1_q <= (ry_q == '0) ? '0 : rf_rdata;
        S_LATCH: begin
          tmp2_q  <= (rz_q == '0) ? '0 : rf_rdata;
          aluop_q <= op_q;
        end
        S_EXEC: begin
          res_q    <= fault ? '0 : alu_result;
          rzero_q  <= fault | alu_zero;
          rcarry_q <= !fault & alu_carry;
          err_q    <= fault;
          ill_q    <= bad_op;
        end
        S_WB: if (!ill_q) begin
          fz_q <= rzero_q;
          fc_q <= rcarry_q;
        end
        default: ;
      endcase
    end
  end

  assign rf_raddr   = raddr_q;
  assign rf_waddr   = rx_q;
  assign rf_wdata   = res_q;
  assign tmp1       = tmp1_q;
  assign tmp2       = tmp2_q;
  assign alu_op     = aluop_q;
  assign flag_zero  = fz_q;
  assign flag_carry = fc_q;

endmodule

// File: tb/tb_hmmm_alu_sequencer.sv
// Bench for hmmm_alu_sequencer: table rows, corner sequences,
// and random requests against a register-array reference model.
module tb_hmmm_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [3:0]  req_rx;
  logic [3:0]  req_ry;
  logic [3:0]  req_rz;
  logic [3:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [15:0] tmp1;
  logic [15:0] tmp2;
  logic [2:0]  alu_op;
  logic        alu_enable;
  logic [15:0] alu_result;
  logic        alu_zero;
  logic        alu_carry;
  logic        flag_zero;
  logic        flag_carry;
  logic        done;
  logic        err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hmmm_alu_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rx     (req_rx),
    .req_ry     (req_ry),
    .req_rz     (req_rz),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .tmp1       (tmp1),
    .tmp2       (tmp2),
    .alu_op     (alu_op),
    .alu_enable (alu_enable),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .done       (done),
    .err        (err)
  );

  typedef struct packed {
    logic [15:0] r;
    logic        z;
    logic        c;
  } alu_t;

  // Signed Hmmm ALU; carry means the true result left 16-bit range
  function automatic alu_t alu_fn(input logic [2:0] op,
                                  input logic [15:0] a,
                                  input logic [15:0] b);
    longint sa, sb, r;
    alu_t o;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 0;
    case (op)
      3'd0: r = sa + sb;
      3'd1: r = sa - sb;
      3'd2: r = sa * sb;
      3'd3: if (sb != 0) r = sa / sb;
      3'd4: if (sb != 0) r = sa % sb;
      default: r = 0;
    endcase
    o.r = r[15:0];
    o.z = (o.r == 16'd0);
    o.c = (r > 32767) || (r < -32768);
    return o;
  endfunction

  alu_t alu_o;
  always_comb alu_o = alu_fn(alu_op, tmp1, tmp2);
  assign alu_result = alu_o.r;
  assign alu_zero   = alu_o.z;
  assign alu_carry  = alu_o.c;

  // Register file; r0 deliberately holds junk the sequencer must ignore
  logic [15:0] rf [16];
  logic        pl_we;
  logic [3:0]  pl_a;
  logic [15:0] pl_d;

  always_ff @(posedge clk) begin
    rf_rdata <= rf[rf_raddr];
    if (pl_we) rf[pl_a] <= pl_d;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  typedef struct packed {
    logic [15:0] r;
    logic        z;
    logic        c;
    logic        e;
    logic        ill;
  } exp_t;

  function automatic exp_t model(input logic [2:0] op,
                                 input logic [15:0] a,
                                 input logic [15:0] b);
    exp_t x;
    alu_t o;
    x.ill = (op > 3'd4);
    x.e = x.ill || ((op == 3'd3 || op == 3'd4) && b == 16'd0);
    if (x.e) begin
      x.r = '0;
      x.z = 1'b1;
      x.c = 1'b0;
    end else begin
      o = alu_fn(op, a, b);
      x.r = o.r;
      x.z = o.z;
      x.c = o.c;
    end
    return x;
  endfunction

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    pl_we = 1'b1;
    pl_a  = a;
    pl_d  = d;
    @(posedge clk);
    #1 pl_we = 1'b0;
  endtask

  // Issue one request and watch seven cycles after acceptance
  task automatic run_req(input logic [2:0] op, input logic [3:0] rx,
                         input logic [3:0] ry, input logic [3:0] rz,
                         output int lat, output int we_n,
                         output logic [3:0] wa, output logic [15:0] wd,
                         output int en_n, output int err_n,
                         output int done_n, output int rdy0,
                         output int rdy_n);
    lat = -1; we_n = 0; wa = '0; wd = '0;
    en_n = 0; err_n = 0; done_n = 0; rdy_n = 0;
    @(negedge clk);
    rdy0 = int'(req_ready);
    req_valid = 1'b1;
    req_op = op; req_rx = rx; req_ry = ry; req_rz = rz;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (c <= 5 && req_ready) rdy_n++;
      if (alu_enable) en_n++;
      if (err) err_n++;
      if (done) begin
        done_n++;
        if (lat < 0) lat = c;
      end
      if (rf_we) begin
        we_n++;
        wa = rf_waddr;
        wd = rf_wdata;
      end
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  rx, ry, rz;
    logic [15:0] a, b;
    logic [15:0] res;
    bit          e, we, fz, fc;
  } vec_t;

  vec_t tbl[12];
  logic [15:0] m [16];
  bit mfz, mfc;

  initial begin
    int lat, we_n, en_n, err_n, done_n, rdy0, rdy_n;
    logic [3:0] wa;
    logic [15:0] wd;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_op = '0; req_rx = '0; req_ry = '0; req_rz = '0;
    pl_we = 1'b0; pl_a = '0; pl_d = '0;

    tbl[0]  = '{3'd0, 4'd1, 4'd2, 4'd3, 16'd3, 16'd2,
                16'd5, 0, 1, 0, 0};
    tbl[1]  = '{3'd1, 4'd4, 4'd2, 4'd3, 16'hFFF9, 16'hFFF9,
                16'd0, 0, 1, 1, 0};
    tbl[2]  = '{3'd1, 4'd4, 4'd2, 4'd3, 16'h7FFF, 16'hFFFE,
                16'h8001, 0, 1, 0, 1};
    tbl[3]  = '{3'd3, 4'd5, 4'd2, 4'd3, 16'hFFF1, 16'd3,
                16'hFFFB, 0, 1, 0, 0};
    tbl[4]  = '{3'd4, 4'd5, 4'd2, 4'd3, 16'hFFF1, 16'd0,
                16'd0, 1, 1, 1, 0};
    tbl[5]  = '{3'd6, 4'd6, 4'd2, 4'd3, 16'd1, 16'd1,
                16'd0, 1, 0, 1, 0};
    tbl[6]  = '{3'd2, 4'd7, 4'd0, 4'd3, 16'd0, 16'd2,
                16'd0, 0, 1, 1, 0};
    tbl[7]  = '{3'd0, 4'd0, 4'd2, 4'd3, 16'd4, 16'd5,
                16'd9, 0, 0, 0, 0};
    tbl[8]  = '{3'd2, 4'd2, 4'd2, 4'd3, 16'd3, 16'd2,
                16'd6, 0, 1, 0, 0};
    tbl[9]  = '{3'd2, 4'd8, 4'd2, 4'd3, 16'd300, 16'd200,
                16'hEA60, 0, 1, 0, 1};
    tbl[10] = '{3'd7, 4'd9, 4'd2, 4'd3, 16'd1, 16'd1,
                16'd0, 1, 0, 0, 1};
    tbl[11] = '{3'd0, 4'd9, 4'd4, 4'd4, 16'hFFFF, 16'hFFFF,
                16'hFFFE, 0, 1, 0, 0};

    preload(4'd0, 16'hBEEF);
    for (int i = 1; i < 16; i++) preload(4'(i), 16'd0);

    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_done_err", {done, err, rf_we, alu_enable}, 0);
    chk("rst_tmp", {tmp1, tmp2, alu_op}, 0);
    chk("rst_rf_ports", {rf_raddr, rf_waddr, rf_wdata}, 0);
    chk("rst_flags", {flag_zero, flag_carry}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].ry != 0) preload(tbl[i].ry, tbl[i].a);
      if (tbl[i].rz != 0 && tbl[i].rz != tbl[i].ry)
        preload(tbl[i].rz, tbl[i].b);
      run_req(tbl[i].op, tbl[i].rx, tbl[i].ry, tbl[i].rz,
              lat, we_n, wa, wd, en_n, err_n, done_n, rdy0, rdy_n);
      chk($sformatf("row%0d_ready_idle", i), rdy0, 1);
      chk($sformatf("row%0d_ready_busy", i), rdy_n, 0);
      chk($sformatf("row%0d_latency", i), lat, 5);
      chk($sformatf("row%0d_done_cnt", i), done_n, 1);
      chk($sformatf("row%0d_err_cnt", i), err_n, int'(tbl[i].e));
      chk($sformatf("row%0d_en_cnt", i), en_n, int'(!tbl[i].e));
      chk($sformatf("row%0d_we_cnt", i), we_n, int'(tbl[i].we));
      if (tbl[i].we) begin
        chk($sformatf("row%0d_waddr", i), wa, tbl[i].rx);
        chk($sformatf("row%0d_wdata", i), wd, tbl[i].res);
        chk($sformatf("row%0d_rf", i), rf[tbl[i].rx], tbl[i].res);
      end
      chk($sformatf("row%0d_fz", i), flag_zero, tbl[i].fz);
      chk($sformatf("row%0d_fc", i), flag_carry, tbl[i].fc);
      chk($sformatf("row%0d_tmp1", i), tmp1,
          (tbl[i].ry == 0) ? 16'd0 : tbl[i].a);
      chk($sformatf("row%0d_tmp2", i), tmp2,
          (tbl[i].rz == 0) ? 16'd0 : tbl[i].b);
      chk($sformatf("row%0d_aluop", i), alu_op, tbl[i].op);
    end

    // Back-to-back with req_valid held high; rx changes while busy
    begin
      int acc[$];
      logic [3:0] wq[$];
      logic [15:0] dq[$];
      preload(4'd2, 16'd1);
      preload(4'd3, 16'd1);
      @(negedge clk);
      req_valid = 1'b1;
      req_op = 3'd0; req_rx = 4'd10; req_ry = 4'd2; req_rz = 4'd3;
      for (int c = 0; c < 16; c++) begin
        if (c > 0) @(negedge clk);
        if (rf_we) begin
          wq.push_back(rf_waddr);
          dq.push_back(rf_wdata);
        end
        if (acc.size() == 1 && c == acc[0] + 1) req_rx = 4'd11;
        if (acc.size() == 2 && c == acc[1] + 1) req_valid = 1'b0;
        if (req_valid && req_ready) acc.push_back(c);
      end
      req_valid = 1'b0;
      chk("b2b_accepts", acc.size(), 2);
      chk("b2b_gap", (acc.size() == 2) ? acc[1] - acc[0] : -1, 6);
      chk("b2b_writes", wq.size(), 2);
      chk("b2b_waddr0", (wq.size() > 0) ? wq[0] : 4'd0, 10);
      chk("b2b_waddr1", (wq.size() > 1) ? wq[1] : 4'd0, 11);
      chk("b2b_wdata1", (dq.size() > 1) ? dq[1] : 16'd0, 2);
    end

    // Reset asserted while the op is in EXEC
    begin
      bit we_seen;
      preload(4'd2, 16'd5);
      preload(4'd3, 16'd6);
      preload(4'd12, 16'h1234);
      @(negedge clk);
      req_valid = 1'b1;
      req_op = 3'd0; req_rx = 4'd12; req_ry = 4'd2; req_rz = 4'd3;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_exec_en", alu_enable, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", req_ready, 1);
      chk("mid_rst_tmp", {tmp1, tmp2, alu_op}, 0);
      chk("mid_rst_ctl", {rf_we, done, err, alu_enable}, 0);
      chk("mid_rst_flags", {flag_zero, flag_carry}, 0);
      we_seen = 1'b0;
      repeat (2) begin
        @(negedge clk);
        we_seen |= rf_we;
      end
      rst_n = 1'b1;
      repeat (6) begin
        @(negedge clk);
        we_seen |= rf_we | done;
      end
      chk("mid_rst_no_write", we_seen, 0);
      chk("mid_rst_ready_after", req_ready, 1);
      chk("mid_rst_r12", rf[12], 16'h1234);
      mfz = 1'b0;
      mfc = 1'b0;
    end

    // Random requests against the register-array model
    for (int i = 1; i < 16; i++) begin
      m[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 4))
                                         : 16'($urandom);
      preload(4'(i), m[i]);
    end
    m[0] = 16'd0;
    for (int t = 0; t < 60; t++) begin
      logic [2:0] op;
      logic [3:0] rx, ry, rz;
      logic [15:0] a, b;
      exp_t x;
      bit we;
      if ($urandom_range(0, 5) == 0) begin
        rx = 4'($urandom_range(1, 15));
        m[rx] = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom);
        preload(rx, m[rx]);
      end
      op = 3'($urandom_range(0, 7));
      rx = 4'($urandom);
      ry = 4'($urandom);
      rz = 4'($urandom);
      a = m[ry];
      b = m[rz];
      x = model(op, a, b);
      we = !x.ill && (rx != 0);
      run_req(op, rx, ry, rz, lat, we_n, wa, wd,
              en_n, err_n, done_n, rdy0, rdy_n);
      if (we) m[rx] = x.r;
      if (!x.ill) begin
        mfz = x.z;
        mfc = x.c;
      end
      chk($sformatf("rnd%0d_latency", t), lat, 5);
      chk($sformatf("rnd%0d_err", t), err_n, int'(x.e));
      chk($sformatf("rnd%0d_en", t), en_n, int'(!x.e));
      chk($sformatf("rnd%0d_we", t), we_n, int'(we));
      if (we) begin
        chk($sformatf("rnd%0d_waddr", t), wa, rx);
        chk($sformatf("rnd%0d_wdata", t), wd, x.r);
      end
      chk($sformatf("rnd%0d_fz", t), flag_zero, mfz);
      chk($sformatf("rnd%0d_fc", t), flag_carry, mfc);
    end
    for (int i = 1; i < 16; i++)
      chk($sformatf("final_r%0d", i), rf[i], m[i]);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
